// File: rtl/spi_slave_bridge.sv
// SPI mode-3 responder: 16-bit header (R/W + address) then 8-bit data phase,
// translated into single-cycle register read/write strobes on clk_i.
module spi_slave_bridge #(
   parameter int HDR_W  = 16,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 7
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              spi_cs_i,
   input  logic              spi_clk_i,
   input  logic              spi_mosi_i,
   output logic              spi_miso_o,
   output logic              spi_miso_t,
   output logic [ADDR_W-1:0] reg_addr_o,
   output logic [DATA_W-1:0] reg_wdata_o,
   output logic              reg_we_o,
   output logic              reg_re_o,
   input  logic [DATA_W-1:0] reg_rdata_i,
   output logic              frame_err_o,
   output logic              busy_o
);

   localparam int TOT   = HDR_W + DATA_W;
   localparam int CNT_W = $clog2(TOT + 1) + 1;
   localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 1);
   localparam logic [CNT_W-1:0] TOT_LAST = CNT_W'(TOT - 1);
   localparam logic [CNT_W-1:0] TOT_CNT  = CNT_W'(TOT);

   typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_e;

   logic [1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
   logic       cs_prev_q, sclk_prev_q;
   logic       cs_s, sclk_s, mosi_s;
   logic       cs_fall, cs_rise, sclk_rise, sclk_fall;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [HDR_W-1:0]    sh_q, sh_d, shifted;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rd_q, rd_d;
   logic                miso_q, miso_d;
   logic                we_q, we_d, re_q, re_d, ld_q, ld_d, err_q, err_d;

   // Idle-level presets keep reset release from looking like a CS fall or SCLK edge
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cs_sync_q   <= 2'b11;
         sclk_sync_q <= 2'b11;
         mosi_sync_q <= 2'b00;
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b1;
      end else begin
         cs_sync_q   <= {cs_sync_q[0], spi_cs_i};
         sclk_sync_q <= {sclk_sync_q[0], spi_clk_i};
         mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
         cs_prev_q   <= cs_s;
         sclk_prev_q <= sclk_s;
      end
   end

   assign cs_s      = cs_sync_q[1];
   assign sclk_s    = sclk_sync_q[1];
   assign mosi_s    = mosi_sync_q[1];
   assign cs_fall   = cs_prev_q & ~cs_s;
   assign cs_rise   = ~cs_prev_q & cs_s;
   assign sclk_rise = ~sclk_prev_q & sclk_s;
   assign sclk_fall = sclk_prev_q & ~sclk_s;
   assign shifted   = {sh_q[HDR_W-2:0], mosi_s};

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         tx_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         miso_q  <= 1'b0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         ld_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         miso_q  <= miso_d;
         we_q    <= we_d;
         re_q    <= re_d;
         ld_q    <= ld_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      tx_d    = ld_q ? reg_rdata_i : tx_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      miso_d  = miso_q;
      we_d    = 1'b0;
      re_d    = 1'b0;
      ld_d    = re_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = HDR;
               cnt_d   = '0;
               sh_d    = '0;
               miso_d  = 1'b0;
            end
         end
         HDR: begin
            if (sclk_rise) begin
               cnt_d = cnt_q + 1'b1;
               sh_d  = shifted;
               if (cnt_q == HDR_LAST) begin
                  addr_d  = shifted[ADDR_W-1:0];
                  rd_d    = shifted[HDR_W-1];
                  re_d    = shifted[HDR_W-1];
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (sclk_rise) begin
               cnt_d = cnt_q + 1'b1;
               sh_d  = shifted;
               if (cnt_q == TOT_LAST) begin
                  state_d = DONE;
                  miso_d  = 1'b0;
                  if (!rd_q) begin
                     wdata_d = shifted[DATA_W-1:0];
                     we_d    = 1'b1;
                  end
               end
            end else if (sclk_fall && rd_q) begin
               miso_d = tx_q[DATA_W-1];
               tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end
         end
         DONE: begin
            // Extra edges only feed the length check, saturating so they never wrap to TOT
            if (sclk_rise && cnt_q != '1) cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // A CS rise is handled after the edge above, so a coincident final edge still completes
      if (state_q != IDLE && cs_rise) begin
         state_d = IDLE;
         miso_d  = 1'b0;
         err_d   = (cnt_d != '0) && (cnt_d != TOT_CNT);
      end
   end

   assign spi_miso_o  = miso_q;
   assign spi_miso_t  = !(state_q == DATA && rd_q);
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;
   assign reg_we_o    = we_q;
   assign reg_re_o    = re_q;
   assign frame_err_o = err_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_bridge.sv
// Directed bench for spi_slave_bridge: a mode-3 SPI master drives frames while a
// small register model answers read strobes.
module tb_spi_slave_bridge;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       cs = 1'b1, sclk = 1'b1, mosi = 1'b0;
   logic       miso, miso_t;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       we, re, ferr, busy;
   logic [7:0] rdata = 8'h00;

   logic [7:0] mem [128];
   logic       use_mem = 1'b0;
   logic [7:0] rd_const = 8'h00;

   int checks = 0, errors = 0;
   int we_tot = 0, re_tot = 0, err_tot = 0;
   logic [6:0] we_addr = '0, re_addr = '0;
   logic [7:0] we_data = '0;

   spi_slave_bridge dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .spi_cs_i    (cs),
      .spi_clk_i   (sclk),
      .spi_mosi_i  (mosi),
      .spi_miso_o  (miso),
      .spi_miso_t  (miso_t),
      .reg_addr_o  (addr),
      .reg_wdata_o (wdata),
      .reg_we_o    (we),
      .reg_re_o    (re),
      .reg_rdata_i (rdata),
      .frame_err_o (ferr),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= use_mem ? mem[addr] : rd_const;
   end

   always @(negedge clk) begin
      if (we) begin
         we_tot  <= we_tot + 1;
         we_addr <= addr;
         we_data <= wdata;
      end
      if (re) begin
         re_tot  <= re_tot + 1;
         re_addr <= addr;
      end
      if (ferr) err_tot <= err_tot + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // word is MSB-aligned: bit i of the frame is word[31-i]; half-period is 8 clk
   task automatic spi_frame(input logic [31:0] word, input int nbits, input bit rd,
                            input bit end_cs, input int gap,
                            output logic [7:0] mb, output int tri_bad);
      mb = 8'h00;
      tri_bad = 0;
      cs = 1'b0;
      wait_clk(8);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b0;
         mosi = word[31-i];
         wait_clk(8);
         if (i >= 16 && i < 24) mb = {mb[6:0], miso};
         if (miso_t !== ((rd && i >= 16 && i < 24) ? 1'b0 : 1'b1)) tri_bad++;
         sclk = 1'b1;
         wait_clk(8);
      end
      if (end_cs) begin
         cs = 1'b1;
         wait_clk(gap);
      end
   endtask

   initial begin
      logic [7:0] mb;
      int tb_bad;
      int we0, re0, err0;

      // reset state
      wait_clk(3);
      check("rst_miso",   miso,   1'b0);
      check("rst_miso_t", miso_t, 1'b1);
      check("rst_addr",   addr,   7'h00);
      check("rst_wdata",  wdata,  8'h00);
      check("rst_we",     we,     1'b0);
      check("rst_re",     re,     1'b0);
      check("rst_err",    ferr,   1'b0);
      check("rst_busy",   busy,   1'b0);
      rstn = 1'b1;
      wait_clk(4);
      check("idle_busy",  busy,   1'b0);

      // write 0x0012 / 0xA5
      we0 = we_tot; re0 = re_tot; err0 = err_tot;
      spi_frame({16'h0012, 8'hA5, 8'h00}, 24, 1'b0, 1'b1, 12, mb, tb_bad);
      check("wr_we_cnt",  we_tot - we0,  1);
      check("wr_addr",    we_addr,       7'h12);
      check("wr_data",    we_data,       8'hA5);
      check("wr_re_cnt",  re_tot - re0,  0);
      check("wr_err_cnt", err_tot - err0, 0);
      check("wr_tri",     tb_bad,        0);
      check("wr_busy",    busy,          1'b0);
      check("wr_hold",    addr,          7'h12);

      // read 0x8034 returning 0x3C
      use_mem = 1'b0; rd_const = 8'h3C;
      we0 = we_tot; re0 = re_tot; err0 = err_tot;
      spi_frame({16'h8034, 8'h00, 8'h00}, 24, 1'b1, 1'b1, 12, mb, tb_bad);
      check("rd_re_cnt",  re_tot - re0,  1);
      check("rd_addr",    re_addr,       7'h34);
      check("rd_miso",    mb,            8'h3C);
      check("rd_tri",     tb_bad,        0);
      check("rd_tri_end", miso_t,        1'b1);
      check("rd_we_cnt",  we_tot - we0,  0);
      check("rd_err_cnt", err_tot - err0, 0);

      // abort after 20 of 24 bits
      we0 = we_tot; err0 = err_tot;
      spi_frame({16'h0005, 8'hFF, 8'h00}, 20, 1'b0, 1'b1, 12, mb, tb_bad);
      check("ab_we_cnt",  we_tot - we0,  0);
      check("ab_err_cnt", err_tot - err0, 1);
      check("ab_busy",    busy,          1'b0);
      we0 = we_tot; err0 = err_tot;
      spi_frame({16'h0006, 8'hC3, 8'h00}, 24, 1'b0, 1'b1, 12, mb, tb_bad);
      check("ab2_we_cnt", we_tot - we0,  1);
      check("ab2_addr",   we_addr,       7'h06);
      check("ab2_data",   we_data,       8'hC3);
      check("ab2_err",    err_tot - err0, 0);

      // overlong frame, 30 bits
      we0 = we_tot; err0 = err_tot;
      spi_frame({16'h0001, 8'h11, 8'hFF}, 30, 1'b0, 1'b1, 12, mb, tb_bad);
      check("ol_we_cnt",  we_tot - we0,  1);
      check("ol_addr",    we_addr,       7'h01);
      check("ol_data",    we_data,       8'h11);
      check("ol_err_cnt", err_tot - err0, 1);
      check("ol_wdata_o", wdata,         8'h11);

      // back-to-back write then loop-back read, 3 clk CS-high gap
      use_mem = 1'b1;
      we0 = we_tot; re0 = re_tot; err0 = err_tot;
      spi_frame({16'h0002, 8'h5A, 8'h00}, 24, 1'b0, 1'b1, 3, mb, tb_bad);
      spi_frame({16'h8002, 8'h00, 8'h00}, 24, 1'b1, 1'b1, 12, mb, tb_bad);
      check("bb_we_cnt",  we_tot - we0,  1);
      check("bb_re_cnt",  re_tot - re0,  1);
      check("bb_re_addr", re_addr,       7'h02);
      check("bb_miso",    mb,            8'h5A);
      check("bb_tri",     tb_bad,        0);
      check("bb_err_cnt", err_tot - err0, 0);

      // reset in the middle of a read
      use_mem = 1'b0; rd_const = 8'hF0;
      spi_frame({16'h8034, 8'h00, 8'h00}, 18, 1'b1, 1'b0, 0, mb, tb_bad);
      check("mr_busy_pre", busy,   1'b1);
      check("mr_tri_pre",  miso_t, 1'b0);
      check("mr_miso_pre", miso,   1'b1);
      rstn = 1'b0;
      #1;
      check("mr_tri",  miso_t, 1'b1);
      check("mr_miso", miso,   1'b0);
      check("mr_we",   we,     1'b0);
      check("mr_re",   re,     1'b0);
      check("mr_err",  ferr,   1'b0);
      check("mr_busy", busy,   1'b0);
      wait_clk(1);
      cs = 1'b1; sclk = 1'b1; mosi = 1'b0;
      wait_clk(3);
      rstn = 1'b1;
      wait_clk(4);
      we0 = we_tot; err0 = err_tot;
      spi_frame({16'h0009, 8'h96, 8'h00}, 24, 1'b0, 1'b1, 12, mb, tb_bad);
      check("pr_we_cnt",  we_tot - we0,  1);
      check("pr_addr",    we_addr,       7'h09);
      check("pr_data",    we_data,       8'h96);
      check("pr_err_cnt", err_tot - err0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
